// File: rtl/mp_addsub_iter.sv
// mp_addsub_iter: chunk-serial multi-precision add/subtract with registered carry.
// Define MPADD_ZERO_FLAG_EN to add the zero-result output.
module mp_addsub_iter #(
    parameter int N = 1027,
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N:0]   result,
    output logic         done,
    output logic         busy
`ifdef MPADD_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);
    localparam int NCHUNK = (N + W - 1) / W;
    localparam int P = NCHUNK * W;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [P-1:0] a_r, b_r, sum_r;
    logic [KW-1:0] k;
    logic c_r, sub_r;
    logic [W:0] s;
    logic [P:0] full;
    assign s = {1'b0, a_r[W-1:0]} + {1'b0, b_r[W-1:0]} + {{W{1'b0}}, c_r};
    // Inverting B across the pad makes the pad bits sign-extend the difference, so
    // bit N is already the borrow; only an unpadded width needs the final carry.
    assign full = {c_r ^ sub_r, sum_r};
    assign result = full[N:0];
    generate
        if (P > N) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^full[P:N+1];
        end
    endgenerate
`ifdef MPADD_ZERO_FLAG_EN
    logic zero_r;
    assign zero = zero_r & ~full[N];
`endif
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            a_r <= '0;
            b_r <= '0;
            sum_r <= '0;
            k <= '0;
            c_r <= 1'b0;
            sub_r <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
`ifdef MPADD_ZERO_FLAG_EN
            zero_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_r <= P'(in_a);
                    b_r <= subtract ? ~P'(in_b) : P'(in_b);
                    c_r <= subtract;
                    sub_r <= subtract;
                    k <= '0;
                    busy <= 1'b1;
                    state <= RUN;
`ifdef MPADD_ZERO_FLAG_EN
                    zero_r <= 1'b1;
`endif
                end
                RUN: begin
                    sum_r[k*W +: W] <= s[W-1:0];
                    c_r <= s[W];
                    a_r <= a_r >> W;
                    b_r <= b_r >> W;
                    k <= k + 1'b1;
`ifdef MPADD_ZERO_FLAG_EN
                    zero_r <= zero_r & (s[W-1:0] == '0);
`endif
                    if (k == KW'(NCHUNK - 1)) state <= DONE;
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_addsub_iter.sv
// tb_mp_addsub_iter: directed checks on a 1027/128 instance and a 200/64 instance.
module tb_mp_addsub_iter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;
    logic start1 = 1'b0, sub1 = 1'b0;
    logic [1026:0] a1 = '0, b1 = '0;
    logic [1027:0] res1;
    logic done1, busy1;
    logic start2 = 1'b0, sub2 = 1'b0;
    logic [199:0] a2 = '0, b2 = '0;
    logic [200:0] res2;
    logic done2, busy2;
`ifdef MPADD_ZERO_FLAG_EN
    logic zero1, zero2;
`endif
    int checks = 0, passed = 0, fails = 0;

    mp_addsub_iter #(.N(1027), .W(128)) d1 (
        .clk(clk), .resetn(resetn), .start(start1), .subtract(sub1),
        .in_a(a1), .in_b(b1), .result(res1), .done(done1), .busy(busy1)
`ifdef MPADD_ZERO_FLAG_EN
        , .zero(zero1)
`endif
    );

    mp_addsub_iter #(.N(200), .W(64)) d2 (
        .clk(clk), .resetn(resetn), .start(start2), .subtract(sub2),
        .in_a(a2), .in_b(b2), .result(res2), .done(done2), .busy(busy2)
`ifdef MPADD_ZERO_FLAG_EN
        , .zero(zero2)
`endif
    );

    task automatic chk(input string tag, input logic [1027:0] obs, input logic [1027:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [1027:0] obs, input logic [1027:0] exp);
        chk({tag, ".hi"}, {514'b0, obs[1027:514]}, {514'b0, exp[1027:514]});
        chk({tag, ".lo"}, {514'b0, obs[513:0]}, {514'b0, exp[513:0]});
    endtask

    // Called at posedge+1; returns in the done cycle (or after the cycle budget with lat=0).
    task automatic op1(input logic [1026:0] a, input logic [1026:0] b, input logic s,
                       output logic [1027:0] r, output int lat);
        start1 = 1'b1; a1 = a; b1 = b; sub1 = s;
        @(posedge clk); #1;
        start1 = 1'b0; a1 = ~a; b1 = ~b; sub1 = ~s;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done1) begin
                lat = i;
                break;
            end
        end
        r = res1;
    endtask

    task automatic op2(input logic [199:0] a, input logic [199:0] b, input logic s,
                       output logic [200:0] r, output int lat);
        start2 = 1'b1; a2 = a; b2 = b; sub2 = s;
        @(posedge clk); #1;
        start2 = 1'b0; a2 = ~a; b2 = ~b; sub2 = ~s;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done2) begin
                lat = i;
                break;
            end
        end
        r = res2;
    endtask

    initial begin
        logic [1027:0] r, e;
        logic [1026:0] pat, ones;
        logic [200:0] r2, e2;
        logic [223:0] ra, rb;
        logic [199:0] x, y;
        logic s;
        int lat, ndone;
        ones = '1;
        pat = {{3{1'b1}}, {32{32'hDEADBEEF}}};
        #12;
        chk("rst_res1", res1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_res2", {827'b0, res2}, 0);
        chk("rst_done2", done2, 0);
        chk("rst_busy2", busy2, 0);
`ifdef MPADD_ZERO_FLAG_EN
        chk("rst_zero1", zero1, 0);
`endif
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        op1(1, 1, 1'b0, r, lat);
        chk("add11_lat", lat, 10);
        chk_wide("add11", r, 2);
        chk("add11_busy", busy1, 0);
        @(posedge clk); #1;
        chk("add11_pulse", done1, 0);
        chk_wide("add11_hold", res1, 2);

        op1(ones, 1, 1'b0, r, lat);
        e = 1028'd1 << 1027;
        chk("ripple_lat", lat, 10);
        chk_wide("ripple", r, e);
`ifdef MPADD_ZERO_FLAG_EN
        chk("ripple_zero", zero1, 0);
`endif

        op1(5, 7, 1'b1, r, lat);
        e = ~1028'd1;
        chk_wide("sub57", r, e);
        chk("sub57_sign", r[1027], 1);
`ifdef MPADD_ZERO_FLAG_EN
        chk("sub57_zero", zero1, 0);
`endif

        op1(pat, pat, 1'b1, r, lat);
        chk_wide("subeq", r, 0);
`ifdef MPADD_ZERO_FLAG_EN
        chk("subeq_zero", zero1, 1);
`endif

        op1(7, 5, 1'b1, r, lat);
        chk_wide("sub75", r, 2);
        chk("sub75_sign", r[1027], 0);

        op1(0, ones, 1'b1, r, lat);
        e = (1028'd1 << 1027) | 1028'd1;
        chk_wide("sub0max", r, e);

        // start pulses during RUN (c=3) and DONE (c=9) must be ignored
        start1 = 1'b1; a1 = 5; b1 = 3; sub1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b0;
        ndone = 0;
        r = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start1 = (c == 3 || c == 9);
            a1 = 100; b1 = 200; sub1 = 1'b1;
            if (c == 9) chk("ign_busy_done_state", busy1, 1);
            if (done1) begin
                ndone++;
                r = res1;
            end
        end
        start1 = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk_wide("ign_res", r, 8);
        chk_wide("ign_hold", res1, 8);
        chk("ign_busy", busy1, 0);

        // reset while k=3
        start1 = 1'b1; a1 = ones; b1 = 1; sub1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        chk_wide("mid_rst_res", res1, 0);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_busy", busy1, 0);
        @(posedge clk); #1;
        chk("mid_rst_done2", done1, 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        op1(1, 1, 1'b0, r, lat);
        chk("after_rst_lat", lat, 10);
        chk_wide("after_rst", r, 2);

        // back-to-back random traffic on the partial-chunk instance
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            x = i == 0 ? 200'd0 : i == 1 ? '1 : i == 2 ? 200'd0 : ra[199:0];
            y = i == 0 ? 200'd0 : i == 1 ? '1 : i == 2 ? 200'd1 : i == 3 ? x : rb[199:0];
            s = i == 0 || i == 2 || i == 3 ? 1'b1 : i == 1 ? 1'b0 : 1'($urandom_range(0, 1));
            e2 = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
            op2(x, y, s, r2, lat);
            chk("rnd_lat", lat, 5);
            chk("rnd_res", {827'b0, r2}, {827'b0, e2});
`ifdef MPADD_ZERO_FLAG_EN
            chk("rnd_zero", zero2, e2 == 0);
`endif
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
